// File: rtl/countdown_timer_if.sv
// Load/done handshake bundle for countdown_timer.
// COUNTDOWN_TIMER_AUTO_RELOAD_EN adds the reload_en_i control.
interface countdown_timer_if #(
  parameter int COUNTER_WIDTH = 8
);
  logic                     load_valid_i;
  logic                     load_ready_o;
  logic [COUNTER_WIDTH-1:0] load_value_i;
  logic                     stop_i;
  logic                     done_valid_o;
  logic                     done_ready_i;
  logic                     busy_o;
  logic [COUNTER_WIDTH-1:0] count_o;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic                     reload_en_i;
`endif

  modport master (
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    output reload_en_i,
`endif
    output load_valid_i, load_value_i, stop_i, done_ready_i,
    input  load_ready_o, done_valid_o, busy_o, count_o
  );

  modport slave (
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    input  reload_en_i,
`endif
    input  load_valid_i, load_value_i, stop_i, done_ready_i,
    output load_ready_o, done_valid_o, busy_o, count_o
  );
endinterface

// File: rtl/countdown_timer.sv
// Programmable load-and-expire down-counter with valid/ready load and done handshakes.
// Optional COUNTDOWN_TIMER_AUTO_RELOAD_EN restarts from the last loaded value on done.
module countdown_timer #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  countdown_timer_if.slave  tmr
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_count;
  logic [COUNTER_WIDTH-1:0] w_count_nxt;
  logic                     w_load_hs;

  assign w_load_hs = tmr.load_valid_i & (r_state == S_IDLE);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [COUNTER_WIDTH-1:0] r_reload;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_reload <= '0;
    end else if (w_load_hs) begin
      r_reload <= tmr.load_value_i;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_load_hs) begin
          w_count_nxt = tmr.load_value_i;
          w_state_nxt = (tmr.load_value_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // stop wins over expiry, even on the final count
        if (tmr.stop_i) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (r_count == COUNTER_WIDTH'(1)) begin
          w_count_nxt = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = r_count - COUNTER_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_count_nxt = '0;
        if (tmr.done_ready_i) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          // a zero reload value keeps the expiry pending
          if (tmr.reload_en_i) begin
            if (r_reload != '0) begin
              w_count_nxt = r_reload;
              w_state_nxt = S_RUN;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign tmr.load_ready_o = (r_state == S_IDLE);
  assign tmr.busy_o       = (r_state == S_RUN);
  assign tmr.done_valid_o = (r_state == S_DONE);
  assign tmr.count_o      = r_count;
endmodule
